fifo_ft: RTL and testbench



---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ptr.sv | 43 ++++
 rtl/fifo_ft.sv | 146 ++++++++++++++
 tb/tb_fifo_ft.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the fall-through FIFO: pointer sizing and wrap-around
// increment for indices into a storage array of arbitrary depth.
package fifo_pkg;

  // Index width for a storage array of `depth` entries, never less than 1 bit.
  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Increment with wrap from depth-1 back to 0, so depth need not be a power of two.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around index counter used for the FIFO read and write pointers.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous reset, active-high (index -> 0)
//   clr_i  - synchronous clear (index -> 0), lower priority than rst_i
//   inc_i  - advance index by one, wrapping at DEPTH-1
//   idx_o  - current index
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = int'(ptr_bits(DEPTH))
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] idx_o
);

  logic [PW-1:0] idx_q;
  logic [PW-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = PW'(next_ptr(32'(idx_q), 32'(DEPTH)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/fifo_ft.sv
// Single-clock register-based FIFO with optional fall-through, push-while-full
// (when paired with a pop), programmable almost-full/almost-empty flags and
// sticky overflow/underflow error flags.
// Ports:
//   clk_i, rst_i          - clock and synchronous active-high reset
//   flush_i               - synchronous flush (same effect as reset, lower priority)
//   push_i, data_i        - write request and data
//   pop_i, data_o         - read request and head entry
//   full_o, empty_o       - usage == DEPTH / usage == 0
//   almost_full_o         - usage >= AF_THRESH
//   almost_empty_o        - usage <= AE_THRESH
//   usage_o               - number of stored entries
//   overflow_o            - sticky: a push was rejected
//   underflow_o           - sticky: a pop was rejected
module fifo_ft
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH   = 32,
  parameter int  DEPTH        = 8,
  parameter bit  FALL_THROUGH = 1'b0,
  parameter int  AF_THRESH    = DEPTH - 1,
  parameter int  AE_THRESH    = 1,
  parameter type DTYPE        = logic [DATA_WIDTH-1:0],
  parameter int  INDEX_BITS   = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  DTYPE                  data_i,
  input  logic                  pop_i,
  output DTYPE                  data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [INDEX_BITS-1:0] usage_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int          PW   = int'(ptr_bits(DEPTH));
  localparam logic [31:0] AF_T = 32'(AF_THRESH);
  localparam logic [31:0] AE_T = 32'(AE_THRESH);

  if (DEPTH < 1) begin : g_depth_check
    $error("fifo_ft: DEPTH must be at least 1");
  end

  DTYPE                  mem_q [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [INDEX_BITS-1:0] usage_q, usage_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic empty, full;
  logic push, pop, bypass;
  logic do_wr, do_rd;

  assign empty = (usage_q == '0);
  assign full  = (usage_q == INDEX_BITS'(DEPTH));

  assign pop    = pop_i & (~empty | (FALL_THROUGH & push_i));
  // When full the pop frees the head slot in the same cycle, so the push fits.
  assign push   = push_i & (~full | pop_i);
  // Empty fall-through push+pop hands data_i straight through; nothing is stored.
  assign bypass = FALL_THROUGH & empty & push_i & pop_i;

  // Flush also suppresses storage/pointer activity so a same-cycle request is ignored.
  assign do_wr = push & ~bypass & ~flush_i;
  assign do_rd = pop  & ~bypass & ~flush_i;

  always_comb begin
    usage_d     = usage_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush_i) begin
      usage_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      case ({do_wr, do_rd})
        2'b10:   usage_d = usage_q + INDEX_BITS'(1);
        2'b01:   usage_d = usage_q - INDEX_BITS'(1);
        default: usage_d = usage_q;
      endcase
      if (push_i & ~push) overflow_d  = 1'b1;
      if (pop_i  & ~pop)  underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      usage_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      usage_q     <= usage_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset/flush.
  always_ff @(posedge clk_i) begin
    if (~rst_i & do_wr) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (do_rd),
    .idx_o (rd_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (do_wr),
    .idx_o (wr_ptr)
  );

  always_comb begin
    if (!empty) begin
      data_o = mem_q[rd_ptr];
    end else if (FALL_THROUGH) begin
      data_o = data_i;
    end else begin
      data_o = '0;
    end
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (32'(usage_q) >= AF_T);
  assign almost_empty_o = (32'(usage_q) <= AE_T);
  assign usage_o        = usage_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_ft.sv
// Directed table-driven bench for fifo_ft (DEPTH=4, DATA_WIDTH=8, AF=3, AE=1),
// with a second fall-through instance exercised by a hand-written sequence.
module tb_fifo_ft;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int IB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, push, pop;
  logic [DW-1:0] din, dout;
  logic          full, empty, af, ae, ovf, udf;
  logic [IB-1:0] usage;

  logic          ft_flush, ft_push, ft_pop;
  logic [DW-1:0] ft_din, ft_dout;
  logic          ft_full, ft_empty, ft_af, ft_ae, ft_ovf, ft_udf;
  logic [IB-1:0] ft_usage;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_ft #(.DATA_WIDTH(DW), .DEPTH(DP), .FALL_THROUGH(1'b0), .AF_THRESH(3), .AE_THRESH(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .data_i(din), .pop_i(pop),
    .data_o(dout), .full_o(full), .empty_o(empty), .almost_full_o(af), .almost_empty_o(ae),
    .usage_o(usage), .overflow_o(ovf), .underflow_o(udf)
  );

  fifo_ft #(.DATA_WIDTH(DW), .DEPTH(DP), .FALL_THROUGH(1'b1), .AF_THRESH(3), .AE_THRESH(1)) u_ft (
    .clk_i(clk), .rst_i(rst), .flush_i(ft_flush), .push_i(ft_push), .data_i(ft_din), .pop_i(ft_pop),
    .data_o(ft_dout), .full_o(ft_full), .empty_o(ft_empty), .almost_full_o(ft_af),
    .almost_empty_o(ft_ae), .usage_o(ft_usage), .overflow_o(ft_ovf), .underflow_o(ft_udf)
  );

  // Inputs for the cycle, and the outputs expected in that cycle before the edge.
  typedef struct {
    logic          rst, flush, push, pop;
    logic [DW-1:0] din;
    int            usage;
    logic [DW-1:0] dout;
    logic          ovf, udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic pu, input logic po,
                     input logic [DW-1:0] d, input int u, input logic [DW-1:0] q,
                     input logic ov, input logic un);
    vec_t v;
    v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.din = d;
    v.usage = u; v.dout = q; v.ovf = ov; v.udf = un;
    vecs.push_back(v);
  endtask

  // Full/empty/almost flags follow from the expected usage for DEPTH=4, AF=3, AE=1.
  function automatic logic [5:0] exp_flags(input int u, input logic ov, input logic un);
    return {(u == 4), (u == 0), (u >= 3), (u <= 1), ov, un};
  endfunction

  task automatic check_ft(input string name, input logic [DW-1:0] q, input int u,
                          input logic e, input logic un);
    logic [10:0] got, exp;
    got = {ft_dout, ft_usage};
    exp = {q, IB'(u)};
    n_vec++;
    if (got !== exp || ft_empty !== e || ft_udf !== un) begin
      n_fail++;
      $display("FAIL %s: got data=%h usage=%0d empty=%b udf=%b, expected data=%h usage=%0d empty=%b udf=%b",
               name, ft_dout, ft_usage, ft_empty, ft_udf, q, u, e, un);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    ft_flush = 1'b0; ft_push = 1'b0; ft_pop = 1'b0; ft_din = '0;

    // Fill / drain, push-while-full, overflow, underflow, flush.
    add(0,0,0,0,8'h00, 0,8'h00,0,0);
    add(0,0,1,0,8'h11, 0,8'h00,0,0);
    add(0,0,1,0,8'h22, 1,8'h11,0,0);
    add(0,0,1,0,8'h33, 2,8'h11,0,0);
    add(0,0,1,0,8'h44, 3,8'h11,0,0);
    add(0,0,0,0,8'h00, 4,8'h11,0,0);
    add(0,0,1,1,8'h55, 4,8'h11,0,0);
    add(0,0,1,0,8'h66, 4,8'h22,0,0);
    add(0,0,0,0,8'h00, 4,8'h22,1,0);
    add(0,0,0,1,8'h00, 4,8'h22,1,0);
    add(0,0,0,1,8'h00, 3,8'h33,1,0);
    add(0,0,0,1,8'h00, 2,8'h44,1,0);
    add(0,0,0,1,8'h00, 1,8'h55,1,0);
    add(0,0,0,1,8'h00, 0,8'h00,1,0);
    add(0,1,1,0,8'h99, 0,8'h00,1,1);
    add(0,0,0,0,8'h00, 0,8'h00,0,0);
    // Wrap: two preloaded entries, then ten push+pop cycles.
    add(0,0,1,0,8'h01, 0,8'h00,0,0);
    add(0,0,1,0,8'h02, 1,8'h01,0,0);
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] head;
      head = (i == 0) ? 8'h01 : (i == 1) ? 8'h02 : 8'(8'hA0 + i - 2);
      add(0,0,1,1,8'(8'hA0 + i), 2,head,0,0);
    end
    add(0,0,0,1,8'h00, 2,8'hA8,0,0);
    add(0,0,0,1,8'h00, 1,8'hA9,0,0);
    add(0,0,0,1,8'h00, 0,8'h00,0,0);
    // Reset mid-operation with push+pop, then fresh data.
    add(0,0,1,0,8'h31, 0,8'h00,0,1);
    add(0,0,1,0,8'h32, 1,8'h31,0,1);
    add(0,0,1,0,8'h33, 2,8'h31,0,1);
    add(1,0,1,1,8'h77, 3,8'h31,0,1);
    add(0,0,1,0,8'h88, 0,8'h00,0,0);
    add(0,0,0,1,8'h00, 1,8'h88,0,0);
    add(0,0,0,0,8'h00, 0,8'h00,0,0);

    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      logic [5:0] gf, ef;
      @(negedge clk);
      rst = vecs[k].rst; flush = vecs[k].flush; push = vecs[k].push;
      pop = vecs[k].pop; din = vecs[k].din;
      #1;
      gf = {full, empty, af, ae, ovf, udf};
      ef = exp_flags(vecs[k].usage, vecs[k].ovf, vecs[k].udf);
      n_vec++;
      if (usage !== IB'(vecs[k].usage) || dout !== vecs[k].dout || gf !== ef) begin
        n_fail++;
        $display("FAIL vec%0d: usage=%0d exp %0d, data=%h exp %h, flags(f,e,af,ae,ov,un)=%b exp %b",
                 k, usage, vecs[k].usage, dout, vecs[k].dout, gf, ef);
      end
      @(posedge clk);
    end

    @(negedge clk);
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;

    // Fall-through instance.
    ft_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ft_flush = 1'b0; ft_push = 1'b1; ft_din = 8'h7E;
    #1 check_ft("ft_same_cycle", 8'h7E, 0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    ft_push = 1'b0; ft_din = 8'h00;
    #1 check_ft("ft_stored", 8'h7E, 1, 1'b0, 1'b0);
    ft_pop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ft_push = 1'b1; ft_pop = 1'b1; ft_din = 8'h5A;
    #1 check_ft("ft_bypass_out", 8'h5A, 0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    ft_push = 1'b0; ft_din = 8'h00;
    #1 check_ft("ft_bypass_after", 8'h00, 0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    ft_pop = 1'b0;
    #1 check_ft("ft_underflow", 8'h00, 0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
